// File: rtl/seg_decode38.sv
// seg_decode38: decodes a 3-to-8 line select and a seven-segment digit, cross-checks them, and buffers each record in a 2-entry FIFO.
// Define SEG_DECODE38_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to zero.
module seg_decode38 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_flag,
    input  logic [6:0] in_seg,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_onehot,
    output logic [3:0] out_hex,
    output logic       out_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [7:0] onehot;
        logic [3:0] hex;
        logic       err;
    } rec_t;

    occ_t       occ;
    occ_t       occ_next;
    rec_t       slot0;
    rec_t       slot1;
    rec_t       dec;
    logic       push;
    logic       pop;
    logic       seg_known;
    logic [3:0] seg_hex;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (occ != EMPTY);

    assign out_onehot = slot0.onehot;
    assign out_hex    = slot0.hex;
    assign out_err    = slot0.err;

    always_comb begin
        seg_known = 1'b1;
        seg_hex   = 4'h0;
        case (in_seg)
            7'h3F: seg_hex = 4'h0;
            7'h06: seg_hex = 4'h1;
            7'h5B: seg_hex = 4'h2;
            7'h4F: seg_hex = 4'h3;
            7'h66: seg_hex = 4'h4;
            7'h6D: seg_hex = 4'h5;
            7'h7D: seg_hex = 4'h6;
            7'h07: seg_hex = 4'h7;
            7'h7F: seg_hex = 4'h8;
            7'h6F: seg_hex = 4'h9;
            7'h77: seg_hex = 4'hA;
            7'h7C: seg_hex = 4'hB;
            7'h39: seg_hex = 4'hC;
            7'h5E: seg_hex = 4'hD;
            7'h79: seg_hex = 4'hE;
            7'h71: seg_hex = 4'hF;
            default: begin
                seg_known = 1'b0;
                seg_hex   = 4'h0;
            end
        endcase
    end

    always_comb begin
        dec        = '0;
        dec.onehot = in_flag ? (8'h01 << in_code) : 8'h00;
        dec.hex    = seg_hex;
        dec.err    = !seg_known
                  || (in_flag  && (seg_hex != {1'b0, in_code}))
                  || (!in_flag && (in_seg != 7'h3F));
    end

    always_comb begin
        occ_next = occ;
        case (occ)
            EMPTY: if (push) occ_next = ONE;
            ONE: begin
                if (push && !pop)      occ_next = FULL;
                else if (!push && pop) occ_next = EMPTY;
            end
            FULL:    if (pop) occ_next = ONE;
            default: occ_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= EMPTY;
        end else begin
            occ <= occ_next;
        end
    end

    // slot0 is always the head; a pop from FULL shifts slot1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0    <= '0;
            slot1    <= '0;
            in_ready <= 1'b0;
        end else begin
            case (occ)
                EMPTY: if (push) slot0 <= dec;
                ONE: begin
                    if (push && pop) slot0 <= dec;
                    else if (push)   slot1 <= dec;
                end
                FULL:    if (pop) slot0 <= slot1;
                default: ;
            endcase
            in_ready <= (occ_next != FULL);
        end
    end

`ifdef SEG_DECODE38_ERRCNT_EN
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (push && dec.err && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign err_cnt = cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg_decode38.sv
// Directed table-driven bench for seg_decode38 plus hand-written backpressure, saturation and reset sequences.
module tb_seg_decode38;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_flag;
    logic [6:0] in_seg;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [3:0] out_hex;
    logic       out_err;
    logic [7:0] err_cnt;

    int unsigned errors;
    int unsigned checks;
    int unsigned exp_cnt;

    seg_decode38 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_flag   (in_flag),
        .in_seg    (in_seg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot),
        .out_hex   (out_hex),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic       flag;
        logic [6:0] seg;
        logic [7:0] onehot;
        logic [3:0] hex;
        logic       err;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] code, input logic flag, input logic [6:0] seg);
        in_valid = 1'b1;
        in_code  = code;
        in_flag  = flag;
        in_seg   = seg;
    endtask

    function automatic logic [7:0] exp_errcnt();
`ifdef SEG_DECODE38_ERRCNT_EN
        return (exp_cnt > 255) ? 8'hFF : exp_cnt[7:0];
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        errors    = 0;
        checks    = 0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        in_flag   = 1'b0;
        in_seg    = '0;
        out_ready = 1'b0;

        vecs[0]  = '{3'd5, 1'b1, 7'h6D, 8'h20, 4'h5, 1'b0};
        vecs[1]  = '{3'd0, 1'b0, 7'h3F, 8'h00, 4'h0, 1'b0};
        vecs[2]  = '{3'd0, 1'b0, 7'h06, 8'h00, 4'h1, 1'b1};
        vecs[3]  = '{3'd2, 1'b1, 7'h00, 8'h04, 4'h0, 1'b1};
        vecs[4]  = '{3'd3, 1'b1, 7'h66, 8'h08, 4'h4, 1'b1};
        vecs[5]  = '{3'd7, 1'b1, 7'h07, 8'h80, 4'h7, 1'b0};
        vecs[6]  = '{3'd0, 1'b1, 7'h3F, 8'h01, 4'h0, 1'b0};
        vecs[7]  = '{3'd1, 1'b1, 7'h06, 8'h02, 4'h1, 1'b0};
        vecs[8]  = '{3'd4, 1'b0, 7'h77, 8'h00, 4'hA, 1'b1};
        vecs[9]  = '{3'd6, 1'b1, 7'h7D, 8'h40, 4'h6, 1'b0};
        vecs[10] = '{3'd2, 1'b1, 7'h5B, 8'h04, 4'h2, 1'b0};
        vecs[11] = '{3'd3, 1'b1, 7'h4F, 8'h08, 4'h3, 1'b0};
        vecs[12] = '{3'd0, 1'b1, 7'h7F, 8'h01, 4'h8, 1'b1};
        vecs[13] = '{3'd6, 1'b0, 7'h71, 8'h00, 4'hF, 1'b1};
        vecs[14] = '{3'd1, 1'b1, 7'h6F, 8'h02, 4'h9, 1'b1};
        vecs[15] = '{3'd4, 1'b1, 7'h7C, 8'h10, 4'hB, 1'b1};
        vecs[16] = '{3'd5, 1'b1, 7'h39, 8'h20, 4'hC, 1'b1};
        vecs[17] = '{3'd7, 1'b1, 7'h79, 8'h80, 4'hE, 1'b1};
        vecs[18] = '{3'd0, 1'b0, 7'h5E, 8'h00, 4'hD, 1'b1};
        vecs[19] = '{3'd1, 1'b1, 7'h7E, 8'h02, 4'h0, 1'b1};

        // Reset state, then in_ready rises one edge after release.
        #3;
        check("rst_in_ready",   in_ready,   0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_onehot", out_onehot, 0);
        check("rst_out_hex",    out_hex,    0);
        check("rst_out_err",    out_err,    0);
        check("rst_err_cnt",    err_cnt,    0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("rel_in_ready_before_edge", in_ready, 0);
        tick();
        check("rel_in_ready_after_edge", in_ready, 1);

        // Table: one push each, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            drive(vecs[i].code, vecs[i].flag, vecs[i].seg);
            tick();
            in_valid = 1'b0;
            if (vecs[i].err) exp_cnt++;
            check($sformatf("v%0d_out_valid", i), out_valid,  1);
            check($sformatf("v%0d_onehot", i),    out_onehot, vecs[i].onehot);
            check($sformatf("v%0d_hex", i),       out_hex,    vecs[i].hex);
            check($sformatf("v%0d_err", i),       out_err,    vecs[i].err);
            check($sformatf("v%0d_err_cnt", i),   err_cnt,    exp_errcnt());
            tick();
            check($sformatf("v%0d_drained", i), out_valid, 0);
        end

        // Backpressure: third push refused, order preserved.
        out_ready = 1'b0;
        drive(3'd1, 1'b1, 7'h06);
        tick();
        drive(3'd2, 1'b1, 7'h5B);
        tick();
        check("bp_full_in_ready", in_ready, 0);
        drive(3'd3, 1'b1, 7'h4F);
        tick();
        check("bp_refused_in_ready", in_ready,   0);
        check("bp_head_stable",      out_onehot, 8'h02);
        check("bp_head_hex_stable",  out_hex,    4'h1);
        out_ready = 1'b1;
        tick();
        check("bp_pop1_valid",     out_valid,  1);
        check("bp_pop1_in_ready",  in_ready,   1);
        check("bp_second_onehot",  out_onehot, 8'h04);
        check("bp_second_hex",     out_hex,    4'h2);
        tick();
        in_valid = 1'b0;
        check("bp_third_valid",  out_valid,  1);
        check("bp_third_onehot", out_onehot, 8'h08);
        check("bp_third_hex",    out_hex,    4'h3);
        check("bp_third_err",    out_err,    0);
        tick();
        check("bp_empty", out_valid, 0);

        // 300 back-to-back erroneous pushes saturate the counter.
        drive(3'd0, 1'b1, 7'h00);
        for (int i = 0; i < 300; i++) begin
            tick();
            exp_cnt++;
        end
        in_valid = 1'b0;
        check("sat_err_cnt", err_cnt, exp_errcnt());
        tick();
        check("sat_drained", out_valid, 0);

        // Mid-operation reset with two entries held.
        out_ready = 1'b0;
        drive(3'd5, 1'b1, 7'h6D);
        tick();
        drive(3'd6, 1'b1, 7'h7D);
        tick();
        in_valid = 1'b0;
        check("mr_full_valid",    out_valid, 1);
        check("mr_full_in_ready", in_ready,  0);
        rst_n = 1'b0;
        #1;
        check("mr_out_valid",  out_valid,  0);
        check("mr_err_cnt",    err_cnt,    0);
        check("mr_in_ready",   in_ready,   0);
        check("mr_out_onehot", out_onehot, 0);
        exp_cnt = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("mr_rel_in_ready_before", in_ready, 0);
        tick();
        check("mr_rel_in_ready_after", in_ready,  1);
        check("mr_rel_out_valid",      out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_decode38.md
SEG_DECODE38 -- requirements
Module: seg_decode38

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: in_valid  in  1  producer offers a record.
REQ-004 SHALL have ports: in_ready  out  1  block accepts a record; registered.
REQ-005 SHALL have ports: in_code  in  3  binary priority-encoder index.
REQ-006 SHALL have ports: in_flag  in  1  encoder "input nonzero and enabled" flag.
REQ-007 SHALL have ports: in_seg  in  7  seven-segment pattern, bit0=a .. bit6=g, active-high.
REQ-008 SHALL have ports: out_valid  out  1  head record available.
REQ-009 SHALL have ports: out_ready  in  1  consumer takes the head record.
REQ-010 SHALL have ports: out_onehot  out  8  decoded one-hot line select.
REQ-011 SHALL have ports: out_hex  out  4  digit recovered from in_seg (0 when pattern unknown).
REQ-012 SHALL have ports: out_err  out  1  record failed the consistency check.
REQ-013 SHALL have ports: err_cnt  out  8  saturating error count.

Function
REQ-014 SHALL push a record when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-015 SHALL buffer records in a 2-entry FIFO, in order, with no drop or duplication.
REQ-016 SHALL drive in_ready = 1 iff fewer than 2 entries are held at the start of the cycle; a push is refused when full even if a pop occurs in the same cycle.
REQ-017 SHALL allow a push and a pop in the same cycle when 1 entry is held; the count stays 1.
REQ-018 SHALL drive out_valid = 1 iff at least 1 entry is held; latency from accepted push to out_valid is exactly 1 cycle.
REQ-019 SHALL compute out_onehot = 1<<in_code when in_flag = 1, else 8'h00; the value is registered at push.
REQ-020 SHALL decode in_seg as: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F; any other pattern is unknown.
REQ-021 SHALL set out_err when any of these hold: the pattern is unknown; in_flag = 1 and the hex value is not {0,in_code}; in_flag = 0 and in_seg is not 3F.
REQ-022 SHALL keep out_onehot, out_hex and out_err stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL increment err_cnt once per accepted push whose out_err is 1, and saturate at 8'hFF.
REQ-024 SHALL ignore in_* contents when no push occurs; out_* contents are don't-care when out_valid = 0.

Reset
REQ-025 SHALL, on rst_n = 0, immediately empty the FIFO and set in_ready=0, out_valid=0, out_onehot=0, out_hex=0, out_err=0 and err_cnt=0.
REQ-026 SHALL raise in_ready on the first clk edge after rst_n deasserts; records in flight at mid-operation reset are discarded.

Configuration
REQ-027 SHALL compile the err_cnt counter in when SEG_DECODE38_ERRCNT_EN is defined.
REQ-028 SHALL, without SEG_DECODE38_ERRCNT_EN, keep the err_cnt port and tie it to 8'h00; out_err is unaffected.

Verification
REQ-029 SHALL cover: push code=5, flag=1, seg=6D with out_ready=1 -> next cycle out_valid=1, onehot=20, hex=5, err=0.
REQ-030 SHALL cover: push flag=0, seg=3F -> onehot=00, hex=0, err=0; push flag=0, seg=06 -> err=1, err_cnt=1.
REQ-031 SHALL cover: push seg=00 -> hex=0, err=1; push code=3, flag=1, seg=66 -> hex=4, err=1.
REQ-032 SHALL cover: out_ready=0 with 3 back-to-back pushes -> third push refused (in_ready=0 after 2 pushes); release out_ready -> records popped in order 1, 2, 3.
REQ-033 SHALL cover: 300 erroneous pushes -> err_cnt=FF (00 when SEG_DECODE38_ERRCNT_EN is undefined).
REQ-034 SHALL cover: rst_n pulsed low with 2 entries held -> out_valid=0 and err_cnt=0 immediately, in_ready=1 one edge after release.
